// File: rtl/pipe_stage_skid_reg_pkg.sv
// rtl/pipe_stage_skid_reg_pkg.sv - state codes and MEM/WB packing widths for the skid pipeline stage
package pipe_stage_skid_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    // MEM/WB payload packing: {PcAddOne, AluOut, DmResult}
    localparam int DM_RESULT_W  = 32;
    localparam int DM_RESULT_LO = 0;
    localparam int ALU_OUT_W    = 32;
    localparam int ALU_OUT_LO   = DM_RESULT_LO + DM_RESULT_W;
    localparam int PC_ADD_ONE_W = 32;
    localparam int PC_ADD_ONE_LO = ALU_OUT_LO + ALU_OUT_W;
    localparam int MEMWB_DATA_W = PC_ADD_ONE_LO + PC_ADD_ONE_W;

    // MEM/WB control packing: {LType, Rw, WbSel, RfWr}
    localparam int RF_WR_LO  = 0;
    localparam int WB_SEL_LO = 1;
    localparam int WB_SEL_W  = 2;
    localparam int RW_LO     = WB_SEL_LO + WB_SEL_W;
    localparam int RW_W      = 5;
    localparam int LTYPE_LO  = RW_LO + RW_W;
    localparam int LTYPE_W   = 8;
    localparam int MEMWB_CTRL_W = LTYPE_LO + LTYPE_W;

endpackage

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - saturating event counter; exists only when PIPE_PERF_CNT_EN is defined
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - valid/ready pipeline register with 2-entry skid and sync flush
// Optional perf counters (stall_cnt/flush_cnt) under PIPE_PERF_CNT_EN.
module pipe_stage_skid_reg
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    state_e            state;
    state_e            stateNxt;
    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] mainCtrl;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] skidCtrl;
    logic              acc;
    logic              pop;
    logic              loadMainIn;
    logic              loadMainSkid;
    logic              loadSkid;

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        case (state)
            ST_EMPTY: if (acc) stateNxt = ST_ONE;
            ST_ONE: begin
                if (acc && !pop)      stateNxt = ST_FULL;
                else if (!acc && pop) stateNxt = ST_EMPTY;
            end
            ST_FULL:  if (pop) stateNxt = ST_ONE;
            default:  stateNxt = ST_EMPTY;
        endcase
        // Flush overrides any accept/pop in the same cycle.
        if (flush) stateNxt = ST_EMPTY;
    end

    // in_ready depends only on the state flop, never on out_ready.
    always_comb begin
        in_ready  = (state != ST_FULL);
        out_valid = (state != ST_EMPTY);
        out_data  = mainData;
        out_ctrl  = out_valid ? mainCtrl : '0;
    end

    always_comb begin
        loadMainIn   = !flush && acc && ((state == ST_EMPTY) || ((state == ST_ONE) && pop));
        loadSkid     = !flush && acc && (state == ST_ONE) && !pop;
        loadMainSkid = !flush && pop && (state == ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainData <= '0;
            mainCtrl <= '0;
            skidData <= '0;
            skidCtrl <= '0;
        end else begin
            if (loadMainIn) begin
                mainData <= in_data;
                mainCtrl <= in_ctrl;
            end else if (loadMainSkid) begin
                mainData <= skidData;
                mainCtrl <= skidCtrl;
            end
            if (loadSkid) begin
                skidData <= in_data;
                skidCtrl <= in_ctrl;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (out_valid & ~out_ready),
        .clr   (1'b0),
        .cnt   (stall_cnt)
    );

    // A flush only counts when it actually kills a held entry.
    pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flush & out_valid),
        .clr   (1'b0),
        .cnt   (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - directed and scoreboard bench for pipe_stage_skid_reg
module tb_pipe_stage_skid_reg;

    localparam int DATA_W = 96;
    localparam int CTRL_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_PERF_CNT_EN
    logic [2:0]        stall_cnt;
    logic [2:0]        flush_cnt;
`endif

    int nTests = 0;
    int nFail  = 0;
    logic [DATA_W+CTRL_W-1:0] sbq[$];

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
`ifdef PIPE_PERF_CNT_EN
        ,
        .CNT_W  (3)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    initial begin
        logic accB;
        logic popB;
        logic [DATA_W+CTRL_W-1:0] head;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_ctrl",  128'(out_ctrl),  128'd0);
        chk("rst_out_data",  128'(out_data),  128'd0);
        chk("rst_in_ready",  128'(in_ready),  128'd1);
`ifdef PIPE_PERF_CNT_EN
        chk("rst_stall_cnt", 128'(stall_cnt), 128'd0);
        chk("rst_flush_cnt", 128'(flush_cnt), 128'd0);
`endif
        rst_n = 1'b1;

        // 1: streaming with 1-cycle lag
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DATA_W'(i), CTRL_W'(16'h100 + i));
            step();
            chk("stream_valid", 128'(out_valid), 128'd1);
            chk("stream_data",  128'(out_data),  128'(i));
            chk("stream_ctrl",  128'(out_ctrl),  128'(16'h100 + i));
        end
        drive(1'b0, '0, '0);
        step();
        chk("stream_drain_valid", 128'(out_valid), 128'd0);
        chk("stream_drain_ctrl",  128'(out_ctrl),  128'd0);

        // 2: stall fills skid, then drains in order
        out_ready = 1'b0;
        drive(1'b1, 96'hA, 16'hA1);
        step();
        chk("stall_A_in_ready", 128'(in_ready), 128'd1);
        chk("stall_A_data",     128'(out_data), 128'hA);
        drive(1'b1, 96'hB, 16'hB1);
        step();
        chk("stall_full_in_ready", 128'(in_ready),  128'd0);
        chk("stall_full_valid",    128'(out_valid), 128'd1);
        chk("stall_full_data",     128'(out_data),  128'hA);
        chk("stall_full_ctrl",     128'(out_ctrl),  128'hA1);
        drive(1'b1, 96'hEE, 16'hEE);
        step();
        chk("stall_hold_data",     128'(out_data), 128'hA);
        chk("stall_hold_in_ready", 128'(in_ready), 128'd0);
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        step();
        chk("stall_pop_B_data",     128'(out_data), 128'hB);
        chk("stall_pop_B_ctrl",     128'(out_ctrl), 128'hB1);
        chk("stall_pop_A_in_ready", 128'(in_ready), 128'd1);
        step();
        chk("stall_empty_valid", 128'(out_valid), 128'd0);

        // 3: flush in FULL with a pending beat, and flush in ONE with a same-cycle accept
        out_ready = 1'b0;
        drive(1'b1, 96'h1A, 16'h1A);
        step();
        drive(1'b1, 96'h1B, 16'h1B);
        step();
        chk("flush_pre_full", 128'(in_ready), 128'd0);
        drive(1'b1, 96'hC, 16'hC1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        chk("flush_full_valid",    128'(out_valid), 128'd0);
        chk("flush_full_ctrl",     128'(out_ctrl),  128'd0);
        chk("flush_full_in_ready", 128'(in_ready),  128'd1);
        out_ready = 1'b1;
        step();
        chk("flush_full_no_C", 128'(out_valid), 128'd0);
        out_ready = 1'b0;
        drive(1'b1, 96'h2A, 16'h2A);
        step();
        drive(1'b1, 96'h2C, 16'h2C);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        chk("flush_one_valid", 128'(out_valid), 128'd0);
        step();
        chk("flush_one_no_C", 128'(out_valid), 128'd0);

        // 4: asynchronous reset while FULL
        drive(1'b1, 96'h3A, 16'h3A);
        step();
        drive(1'b1, 96'h3B, 16'h3B);
        step();
        drive(1'b0, '0, '0);
        chk("arst_pre_full", 128'(in_ready), 128'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'd0);
        chk("arst_out_ctrl",  128'(out_ctrl),  128'd0);
        chk("arst_in_ready",  128'(in_ready),  128'd1);
        chk("arst_out_data",  128'(out_data),  128'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("arst_no_old_beat", 128'(out_valid), 128'd0);

        // 5: random valid/ready against a scoreboard FIFO
        sbq.delete();
        for (int n = 0; n < 2000; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = {$urandom(), $urandom(), $urandom()};
            in_ctrl   = 16'($urandom());
            #3;
            chk("rnd_out_valid", 128'(out_valid), 128'(sbq.size() != 0));
            chk("rnd_in_ready",  128'(in_ready),  128'(sbq.size() < 2));
            if (!out_valid) chk("rnd_ctrl_gated", 128'(out_ctrl), 128'd0);
            accB = in_valid & in_ready;
            popB = out_valid & out_ready;
            if (popB && sbq.size() != 0) begin
                head = sbq.pop_front();
                chk("rnd_data", 128'(out_data), 128'(head[DATA_W-1:0]));
                chk("rnd_ctrl", 128'(out_ctrl), 128'(head[DATA_W+CTRL_W-1:DATA_W]));
            end
            if (accB) sbq.push_back({in_ctrl, in_data});
            step();
        end
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        step();
        step();
        chk("rnd_drained", 128'(out_valid), 128'd0);

`ifdef PIPE_PERF_CNT_EN
        // 6: perf counters (CNT_W=3, saturate at 7)
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 96'h5A, 16'h5A);
        step();
        drive(1'b0, '0, '0);
        repeat (5) step();
        out_ready = 1'b1;
        step();
        chk("perf_stall_5", 128'(stall_cnt), 128'd5);
        drive(1'b1, 96'h6A, 16'h6A);
        step();
        drive(1'b0, '0, '0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b1, 96'h6B, 16'h6B);
        step();
        drive(1'b0, '0, '0);
        flush = 1'b1;
        step();
        step();
        flush = 1'b0;
        chk("perf_flush_2", 128'(flush_cnt), 128'd2);
        chk("perf_stall_after_flush", 128'(stall_cnt), 128'd5);
        out_ready = 1'b0;
        drive(1'b1, 96'h7A, 16'h7A);
        step();
        drive(1'b0, '0, '0);
        repeat (4) step();
        chk("perf_stall_sat", 128'(stall_cnt), 128'd7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
